// File: rtl/vector_issue_controller_pkg.sv
// Shared encodings for the vector issue controller and the vector function unit it drives.
// Status values must stay in lock-step with the FU's status output.
package vector_issue_controller_pkg;

    typedef enum logic [1:0] {
        VEC_ALU_NOP      = 2'd0,
        VEC_ALU_WORKING  = 2'd1,
        VEC_ALU_FINISHED = 2'd2
    } vec_alu_status_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } issue_state_e;

    typedef enum logic [1:0] {
        OP_VV = 2'd0,
        OP_VX = 2'd1,
        OP_VI = 2'd2
    } operand_type_e;

endpackage

// File: rtl/vector_issue_controller_if.sv
// Decode -> controller -> FU -> register-file bus. master = controller side,
// slave = decode/FU/regfile side.
interface vector_issue_controller_if #(
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3
);
    localparam int VW = VECTOR_SIZE * LEN;
    localparam int LW = ENTRY_INDEX_SIZE + 1;

    logic                   instr_valid;
    logic                   instr_ready;
    logic [LW-1:0]          instr_vl;
    logic [VW-1:0]          instr_vs1;
    logic [VW-1:0]          instr_vs2;
    logic [VW-1:0]          instr_mask;
    logic                   instr_vm;
    logic [LEN-1:0]         instr_imm;
    logic [LEN-1:0]         instr_rs;
    logic [2:0]             instr_alu_signal;
    logic [1:0]             instr_operand_type;
    logic [5:0]             instr_funct6;
    logic [4:0]             instr_vd;

    logic                   fu_execute;
    logic [LW-1:0]          fu_length;
    logic [VW-1:0]          fu_vs1;
    logic [VW-1:0]          fu_vs2;
    logic [VW-1:0]          fu_mask;
    logic [LEN-1:0]         fu_imm;
    logic [LEN-1:0]         fu_rs;
    logic [2:0]             fu_alu_signal;
    logic [1:0]             fu_operand_type;
    logic [5:0]             fu_funct6;
    logic [VW-1:0]          fu_result;
    logic [1:0]             fu_status;

    logic                   wb_valid;
    logic [4:0]             wb_vd;
    logic [VW-1:0]          wb_data;
    logic [VECTOR_SIZE-1:0] wb_elem_en;

    modport master (
        input  instr_valid, instr_vl, instr_vs1, instr_vs2, instr_mask, instr_vm,
               instr_imm, instr_rs, instr_alu_signal, instr_operand_type,
               instr_funct6, instr_vd, fu_result, fu_status,
        output instr_ready, fu_execute, fu_length, fu_vs1, fu_vs2, fu_mask,
               fu_imm, fu_rs, fu_alu_signal, fu_operand_type, fu_funct6,
               wb_valid, wb_vd, wb_data, wb_elem_en
    );

    modport slave (
        output instr_valid, instr_vl, instr_vs1, instr_vs2, instr_mask, instr_vm,
               instr_imm, instr_rs, instr_alu_signal, instr_operand_type,
               instr_funct6, instr_vd, fu_result, fu_status,
        input  instr_ready, fu_execute, fu_length, fu_vs1, fu_vs2, fu_mask,
               fu_imm, fu_rs, fu_alu_signal, fu_operand_type, fu_funct6,
               wb_valid, wb_vd, wb_data, wb_elem_en
    );

endinterface

// File: rtl/vector_issue_controller_wb_enable_gen.sv
// Per-element writeback enable: element i is written when it lies inside the
// clamped vector length and is either unmasked or its mask bit is set.
module vector_wb_enable_gen #(
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3
) (
    input  logic [ENTRY_INDEX_SIZE:0]  i_len,
    input  logic                       i_vm,
    input  logic [VECTOR_SIZE-1:0]     i_mask_lsb,
    output logic [VECTOR_SIZE-1:0]     o_en
);
    localparam int LW = ENTRY_INDEX_SIZE + 1;

    for (genvar i = 0; i < VECTOR_SIZE; i++) begin : g_elem
        assign o_en[i] = (LW'(i) < i_len) & (i_vm | i_mask_lsb[i]);
    end

endmodule

// File: rtl/vector_issue_controller.sv
// Single-in-flight issue controller: latches a decoded vector instruction, drives the FU,
// tracks its WORKING->FINISHED handshake and emits a one-cycle writeback.
// Optional watchdog on the FU wait: define VEC_ISSUE_TIMEOUT_EN.
module vector_issue_controller
    import vector_issue_controller_pkg::*;
#(
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int LANE_SIZE        = 2,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy_in,
    vector_issue_controller_if.master bus,
    output logic                    busy,
    output logic                    timeout_err
);
    localparam int VW = VECTOR_SIZE * LEN;
    localparam int LW = ENTRY_INDEX_SIZE + 1;

    if (LANE_SIZE < 1 || TIMEOUT_CYCLES < 2 || VECTOR_SIZE != (1 << ENTRY_INDEX_SIZE)) begin : g_bad_cfg
        $error("vector_issue_controller: inconsistent parameters");
    end

    issue_state_e           r_state, w_next;
    logic                   r_seen_working;
    logic [LW-1:0]          r_len;
    logic [VW-1:0]          r_vs1, r_vs2, r_mask;
    logic                   r_vm;
    logic [LEN-1:0]         r_imm, r_rs;
    logic [2:0]             r_alu;
    logic [1:0]             r_optype;
    logic [5:0]             r_funct6;
    logic [4:0]             r_vd;
    logic [VW-1:0]          r_wb_data;
    logic [4:0]             r_wb_vd;
    logic [VECTOR_SIZE-1:0] r_wb_en;

    logic                   w_ready, w_accept, w_fin, w_to_hit;
    logic [LW-1:0]          w_len_clamp;
    logic [VECTOR_SIZE-1:0] w_mask_lsb, w_elem_en;

    assign w_ready     = (r_state == ST_IDLE) & rdy_in;
    assign w_accept    = bus.instr_valid & w_ready;
    assign w_len_clamp = (bus.instr_vl > LW'(VECTOR_SIZE)) ? LW'(VECTOR_SIZE) : bus.instr_vl;
    // A FINISHED not preceded by WORKING belongs to an older op and is ignored.
    assign w_fin       = (r_state == ST_WAIT) & (bus.fu_status == VEC_ALU_FINISHED) & r_seen_working;

    for (genvar i = 0; i < VECTOR_SIZE; i++) begin : g_mlsb
        assign w_mask_lsb[i] = r_mask[i*LEN];
    end

    vector_wb_enable_gen #(
        .VECTOR_SIZE      (VECTOR_SIZE),
        .ENTRY_INDEX_SIZE (ENTRY_INDEX_SIZE)
    ) u_wb_en (
        .i_len      (r_len),
        .i_vm       (r_vm),
        .i_mask_lsb (w_mask_lsb),
        .o_en       (w_elem_en)
    );

`ifdef VEC_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] r_to_cnt;
    logic          r_timeout;

    assign w_to_hit = (r_state == ST_WAIT) & ~w_fin & (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_hit;
            if (r_state != ST_WAIT) r_to_cnt <= '0;
            else if (!w_to_hit)     r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign timeout_err = r_timeout;
`else
    assign w_to_hit    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && bus.instr_vl != '0) w_next = ST_ISSUE;
            ST_ISSUE: if (rdy_in) w_next = ST_WAIT;
            ST_WAIT:  begin
                if (w_fin)         w_next = ST_WB;
                else if (w_to_hit) w_next = ST_IDLE;
            end
            ST_WB:    w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_seen_working <= 1'b0;
            r_len          <= '0;
            r_vs1          <= '0;
            r_vs2          <= '0;
            r_mask         <= '0;
            r_vm           <= 1'b0;
            r_imm          <= '0;
            r_rs           <= '0;
            r_alu          <= '0;
            r_optype       <= '0;
            r_funct6       <= '0;
            r_vd           <= '0;
            r_wb_data      <= '0;
            r_wb_vd        <= '0;
            r_wb_en        <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_len    <= w_len_clamp;
                r_vs1    <= bus.instr_vs1;
                r_vs2    <= bus.instr_vs2;
                r_mask   <= bus.instr_mask;
                r_vm     <= bus.instr_vm;
                r_imm    <= bus.instr_imm;
                r_rs     <= bus.instr_rs;
                r_alu    <= bus.instr_alu_signal;
                r_optype <= bus.instr_operand_type;
                r_funct6 <= bus.instr_funct6;
                r_vd     <= bus.instr_vd;
            end
            if (r_state == ST_ISSUE && rdy_in)
                r_seen_working <= 1'b0;
            else if (r_state == ST_WAIT && bus.fu_status == VEC_ALU_WORKING)
                r_seen_working <= 1'b1;
            if (w_fin) begin
                r_wb_data <= bus.fu_result;
                r_wb_vd   <= r_vd;
                r_wb_en   <= w_elem_en;
            end
        end
    end

    assign bus.instr_ready     = w_ready;
    assign bus.fu_execute      = (r_state == ST_ISSUE) & rdy_in;
    assign bus.fu_length       = r_len;
    assign bus.fu_vs1          = r_vs1;
    assign bus.fu_vs2          = r_vs2;
    assign bus.fu_mask         = r_mask;
    assign bus.fu_imm          = r_imm;
    assign bus.fu_rs           = r_rs;
    assign bus.fu_alu_signal   = r_alu;
    assign bus.fu_operand_type = r_optype;
    assign bus.fu_funct6       = r_funct6;
    assign bus.wb_valid        = (r_state == ST_WB);
    assign bus.wb_vd           = r_wb_vd;
    assign bus.wb_data         = r_wb_data;
    assign bus.wb_elem_en      = r_wb_en;
    assign busy                = (r_state != ST_IDLE);

endmodule

// File: tb/tb_vector_issue_controller.sv
// Scoreboard bench: the driver pushes expected writebacks, a negedge monitor pops and
// compares whenever wb_valid is seen; a behavioural FU answers the execute requests.
module tb_vector_issue_controller;
    localparam int LEN = 32;
    localparam int VS  = 8;
    localparam int EIS = 3;
    localparam int LS  = 2;
    localparam int TO  = 16;
    localparam int VW  = VS * LEN;

    logic clk, rst, rdy_in, busy, timeout_err;
    int   cyc, n_chk, n_pass, n_exec, n_to, to_cyc, acc_cyc;

    typedef struct {
        logic [4:0]    vd;
        logic [VW-1:0] data;
        logic [VS-1:0] en;
        logic [3:0]    len;
        logic [VW-1:0] vs1;
        logic [5:0]    f6;
        int            lat;
    } exp_t;
    exp_t sb[$];

    vector_issue_controller_if #(.LEN(LEN), .VECTOR_SIZE(VS), .ENTRY_INDEX_SIZE(EIS)) bus();

    vector_issue_controller #(
        .LEN(LEN), .VECTOR_SIZE(VS), .ENTRY_INDEX_SIZE(EIS), .LANE_SIZE(LS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in), .bus(bus), .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FU: WORKING for ceil(len/LS) cycles after an optional start delay.
    logic [1:0]     fu_st;
    logic           fu_pend;
    int             fu_cnt, fu_dly, cfg_dly;
    bit             cfg_stuck;
    logic [LEN-1:0] cfg_pat, cfg_inc;
    logic [VW-1:0]  fu_res;

    assign bus.fu_status = fu_st;
    assign bus.fu_result = fu_res;

    function automatic logic [VW-1:0] mk_res(logic [LEN-1:0] p, logic [LEN-1:0] inc);
        logic [VW-1:0] r;
        for (int i = 0; i < VS; i++) r[i*LEN +: LEN] = p + LEN'(i) * inc;
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fu_st <= 2'd0; fu_pend <= 1'b0; fu_cnt <= 0; fu_dly <= 0; fu_res <= '0;
        end else if (bus.fu_execute && fu_st != 2'd1 && !fu_pend) begin
            if (cfg_dly == 0) begin
                fu_st <= 2'd1; fu_cnt <= (int'(bus.fu_length) + LS - 1) / LS;
            end else begin
                fu_pend <= 1'b1; fu_dly <= cfg_dly;
            end
        end else if (fu_pend) begin
            if (fu_dly == 1) begin
                fu_pend <= 1'b0; fu_st <= 2'd1; fu_cnt <= (int'(bus.fu_length) + LS - 1) / LS;
            end else fu_dly <= fu_dly - 1;
        end else if (fu_st == 2'd1 && !cfg_stuck) begin
            if (fu_cnt <= 1) begin
                fu_st <= 2'd2; fu_res <= mk_res(cfg_pat, cfg_inc);
            end else fu_cnt <= fu_cnt - 1;
        end
    end

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) n_exec = 0;
        else begin
            if (bus.fu_execute) n_exec++;
            if (timeout_err) begin n_to++; to_cyc = cyc; n_exec = 0; end
            if (bus.wb_valid) begin
                if (sb.size() == 0) chk("wb_unexpected", 1'b1, 1'b0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wb_vd", bus.wb_vd, e.vd);
                    chk("wb_data", bus.wb_data, e.data);
                    chk("wb_elem_en", bus.wb_elem_en, e.en);
                    chk("fu_length", bus.fu_length, e.len);
                    chk("fu_vs1", bus.fu_vs1, e.vs1);
                    chk("fu_funct6", bus.fu_funct6, e.f6);
                    chk("exec_pulses", n_exec, 1);
                    chk("wb_latency", cyc - acc_cyc, e.lat);
                end
                n_exec = 0;
            end
        end
    end

    task automatic present(input logic [3:0] vl, input logic vm, input logic [VW-1:0] mask,
                           input logic [4:0] vd, input logic [VW-1:0] vs1, input logic [5:0] f6);
        int t;
        @(negedge clk);
        bus.instr_vl = vl; bus.instr_vm = vm; bus.instr_mask = mask; bus.instr_vd = vd;
        bus.instr_vs1 = vs1; bus.instr_vs2 = ~vs1; bus.instr_funct6 = f6;
        bus.instr_imm = 32'h1F; bus.instr_rs = 32'hCAFE_0001; bus.instr_alu_signal = 3'd2;
        bus.instr_operand_type = 2'd0; bus.instr_valid = 1'b1;
        t = 0;
        while (!bus.instr_ready && t < 50) begin @(negedge clk); t++; end
        chk("accept_bound", t < 50, 1'b1);
        acc_cyc = cyc + 1;
    endtask

    task automatic run(input logic [3:0] vl, input logic vm, input logic [VW-1:0] mask,
                       input logic [4:0] vd, input logic [LEN-1:0] pat, input logic [LEN-1:0] inc,
                       input int dly, input int stall, input logic [VS-1:0] exp_en,
                       input logic [3:0] exp_len, input int exp_lat);
        int t;
        logic [VW-1:0] vs1;
        exp_t e;
        vs1 = mk_res(32'h1000_0000 + 32'(vd), 32'h11);
        cfg_pat = pat; cfg_inc = inc; cfg_dly = dly;
        present(vl, vm, mask, vd, vs1, 6'(vd + 5'd3));
        if (vl != 0) begin
            e.vd = vd; e.data = mk_res(pat, inc); e.en = exp_en; e.len = exp_len;
            e.vs1 = vs1; e.f6 = 6'(vd + 5'd3); e.lat = exp_lat;
            sb.push_back(e);
        end
        @(posedge clk); #1 bus.instr_valid = 1'b0;
        if (vl == 0) begin
            @(negedge clk);
            chk("vl0_ready", bus.instr_ready, 1'b1);
            chk("vl0_busy", busy, 1'b0);
            repeat (3) @(negedge clk);
            chk("vl0_no_exec", n_exec, 0);
        end
        if (stall > 0) begin
            rdy_in = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                chk("stall_exec", bus.fu_execute, 1'b0);
                @(posedge clk);
            end
            #1 rdy_in = 1'b1;
        end
        t = 0;
        while (busy && t < 300) begin @(negedge clk); t++; end
        chk("done_bound", t < 300, 1'b1);
    endtask

    initial begin
        logic [VW-1:0] m;
        int t;
        cyc = 0; n_chk = 0; n_pass = 0; n_exec = 0; n_to = 0; to_cyc = 0; acc_cyc = 0;
        cfg_dly = 0; cfg_stuck = 0; cfg_pat = '0; cfg_inc = '0;
        rst = 1'b1; rdy_in = 1'b0;
        bus.instr_valid = 1'b0; bus.instr_vl = '0; bus.instr_vs1 = '0; bus.instr_vs2 = '0;
        bus.instr_mask = '0; bus.instr_vm = 1'b0; bus.instr_imm = '0; bus.instr_rs = '0;
        bus.instr_alu_signal = '0; bus.instr_operand_type = '0; bus.instr_funct6 = '0;
        bus.instr_vd = '0;
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", bus.instr_ready, 1'b0);
        chk("rst_exec", bus.fu_execute, 1'b0);
        chk("rst_wb_valid", bus.wb_valid, 1'b0);
        chk("rst_wb_data", bus.wb_data, '0);
        chk("rst_wb_en", bus.wb_elem_en, '0);
        chk("rst_fu_length", bus.fu_length, '0);
        chk("rst_timeout", timeout_err, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1; rdy_in = 1'b1;

        run(4'd8, 1'b1, '0, 5'd7, 32'hA5A5_A5A5, 32'h0, 0, 0, 8'hFF, 4'd8, 6);
        m = '0;
        for (int i = 0; i < VS; i += 2) m[i*LEN] = 1'b1;
        m[LEN +: LEN] = 32'h2;
        run(4'd5, 1'b0, m, 5'd12, 32'h5000_0000, 32'h3, 0, 0, 8'b0001_0101, 4'd5, 5);
        run(4'd0, 1'b1, '0, 5'd9, 32'hDEAD_0000, 32'h1, 0, 0, 8'h00, 4'd0, 0);
        run(4'd4, 1'b1, '0, 5'd3, 32'h1111_0000, 32'h1, 3, 0, 8'h0F, 4'd4, 7);
        run(4'd8, 1'b1, '0, 5'd20, 32'h0BAD_F00D, 32'h100, 0, 3, 8'hFF, 4'd8, 9);
        run(4'd12, 1'b1, '0, 5'd31, 32'h7777_0000, 32'h10, 0, 0, 8'hFF, 4'd8, 6);
        run(4'd1, 1'b0, '1, 5'd1, 32'h0000_00F1, 32'h1, 0, 0, 8'h01, 4'd1, 3);

`ifdef VEC_ISSUE_TIMEOUT_EN
        cfg_stuck = 1'b1;
        present(4'd8, 1'b1, '0, 5'd5, '1, 6'd1);
        @(posedge clk); #1 bus.instr_valid = 1'b0;
        t = 0;
        while (n_to == 0 && t < 100) begin @(negedge clk); t++; end
        chk("to_bound", t < 100, 1'b1);
        chk("to_cycle", to_cyc - acc_cyc, TO + 1);
        chk("to_idle", busy, 1'b0);
        @(negedge clk);
        chk("to_pulse_width", timeout_err, 1'b0);
        chk("to_count", n_to, 1);
        cfg_stuck = 1'b0;
`endif

        cfg_stuck = 1'b1;
        present(4'd8, 1'b1, '0, 5'd11, '1, 6'd2);
        @(posedge clk); #1 bus.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_wait_busy", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_wb_valid", bus.wb_valid, 1'b0);
        chk("mrst_wb_data", bus.wb_data, '0);
        chk("mrst_wb_en", bus.wb_elem_en, '0);
        chk("mrst_wb_vd", bus.wb_vd, '0);
        chk("mrst_fu_length", bus.fu_length, '0);
        chk("mrst_fu_vs1", bus.fu_vs1, '0);
        chk("mrst_exec", bus.fu_execute, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1; cfg_stuck = 1'b0;
        run(4'd2, 1'b1, '0, 5'd17, 32'h2468_0000, 32'h2, 0, 0, 8'h03, 4'd2, 3);

        repeat (4) @(negedge clk);
`ifndef VEC_ISSUE_TIMEOUT_EN
        chk("no_timeout", n_to, 0);
`endif
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
